// File: rtl/hash_scheduler.sv
// Once-per-second hash launcher with timeout supervision and display-source selection.
// Optional HASH_SCHED_OVERRUN_CNT_EN adds a saturating missed_ticks counter for dropped ticks.
module hash_scheduler #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] cur_time,
  input  logic [WIDTH-1:0] student_id,
  input  logic             button_pulse,
  input  logic             hash_done,
  input  logic [WIDTH-1:0] hash_result,
  output logic             hash_start,
  output logic [WIDTH-1:0] hash_time,
  output logic [WIDTH-1:0] hash_id,
  output logic [WIDTH-1:0] disp_value,
  output logic [1:0]       disp_mode,
  output logic             busy,
  output logic             timeout_err,
`ifdef HASH_SCHED_OVERRUN_CNT_EN
  output logic [7:0]       missed_ticks,
`endif
  output logic [1:0]       state_dbg
);

  // Hasher handshake: hash_start is a single-cycle strobe while in START; the operands
  // on hash_time/hash_id stay stable until the FSM is back in IDLE. hash_done is only
  // honoured in WAIT, where hash_result is taken on the same edge.

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             pending, pending_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hash_reg, hash_n;
  logic [WIDTH-1:0] frozen_reg, frozen_n;
  logic [WIDTH-1:0] time_n, id_n, disp_n;
  logic [1:0]       mode_n;
  logic             err_n;

  assign hash_start = (state == START);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      cnt         <= '0;
      hash_reg    <= '0;
      frozen_reg  <= '0;
      hash_time   <= '0;
      hash_id     <= '0;
      disp_value  <= '0;
      disp_mode   <= 2'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      cnt         <= cnt_n;
      hash_reg    <= hash_n;
      frozen_reg  <= frozen_n;
      hash_time   <= time_n;
      hash_id     <= id_n;
      disp_value  <= disp_n;
      disp_mode   <= mode_n;
      timeout_err <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    cnt_n     = cnt;
    hash_n    = hash_reg;
    time_n    = hash_time;
    id_n      = hash_id;
    err_n     = timeout_err;
    case (state)
      IDLE: begin
        if (tick_in || pending) begin
          time_n    = cur_time;
          id_n      = student_id;
          pending_n = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
        if (tick_in) pending_n = 1'b1;
      end
      WAIT: begin
        cnt_n = cnt + CNT_ONE;
        if (tick_in) pending_n = 1'b1;
        // A completion on the final allowed cycle still counts as a success.
        if (hash_done) begin
          hash_n  = hash_result;
          state_n = IDLE;
        end else if (cnt == TO_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        pending_n = 1'b0;
      end
    endcase
  end

  // Display path looks at next-state values so a mode change and a capture on the
  // same edge are both reflected in the registered word.
  always_comb begin
    mode_n   = disp_mode;
    frozen_n = frozen_reg;
    disp_n   = '0;
    if (button_pulse) begin
      mode_n = disp_mode + 2'd1;
      if (disp_mode == 2'd2) frozen_n = hash_reg;
    end
    case (mode_n)
      2'd0:    disp_n = hash_n;
      2'd1:    disp_n = cur_time;
      2'd2:    disp_n = student_id;
      default: disp_n = frozen_n;
    endcase
  end

`ifdef HASH_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      missed_ticks <= 8'd0;
    end else if (tick_in && pending && (state != IDLE) && (missed_ticks != 8'hFF)) begin
      missed_ticks <= missed_ticks + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_scheduler.sv
// Directed bench for hash_scheduler with TIMEOUT_CYCLES=8; overrun checks follow
// HASH_SCHED_OVERRUN_CNT_EN.
`timescale 1ns/1ps
module tb_hash_scheduler;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic [15:0] cur_time;
  logic [15:0] student_id;
  logic        button_pulse;
  logic        hash_done;
  logic [15:0] hash_result;
  logic        hash_start;
  logic [15:0] hash_time;
  logic [15:0] hash_id;
  logic [15:0] disp_value;
  logic [1:0]  disp_mode;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  state_dbg;
`ifdef HASH_SCHED_OVERRUN_CNT_EN
  logic [7:0]  missed_ticks;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Clock / reset block: 1 MHz.
  always #500 sysclk = ~sysclk;

  hash_scheduler #(.WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .tick_in      (tick_in),
    .cur_time     (cur_time),
    .student_id   (student_id),
    .button_pulse (button_pulse),
    .hash_done    (hash_done),
    .hash_result  (hash_result),
    .hash_start   (hash_start),
    .hash_time    (hash_time),
    .hash_id      (hash_id),
    .disp_value   (disp_value),
    .disp_mode    (disp_mode),
    .busy         (busy),
    .timeout_err  (timeout_err),
`ifdef HASH_SCHED_OVERRUN_CNT_EN
    .missed_ticks (missed_ticks),
`endif
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 ns after the rising edge, checks happen there too.
  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic launch(input logic [15:0] t);
    cur_time = t;
    tick_in  = 1'b1;
    cyc();
    tick_in  = 1'b0;
  endtask

  task automatic complete(input logic [15:0] r);
    hash_result = r;
    hash_done   = 1'b1;
    cyc();
    hash_done   = 1'b0;
  endtask

  task automatic press();
    button_pulse = 1'b1;
    cyc();
    button_pulse = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_in = 1'b0; cur_time = '0; student_id = '0;
    button_pulse = 1'b0; hash_done = 1'b0; hash_result = '0;
    cyc(); cyc();
    chk("rst_hash_start", hash_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hash_time", hash_time, 0);
    chk("rst_disp_value", disp_value, 0);
    chk("rst_disp_mode", disp_mode, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    cyc();

    // Basic launch and capture.
    student_id = 16'h1234;
    launch(16'h0005);
    chk("l_start", hash_start, 1);
    chk("l_busy", busy, 1);
    chk("l_time", hash_time, 16'h0005);
    chk("l_id", hash_id, 16'h1234);
    cur_time = 16'h0007;
    cyc();
    chk("l_start_pulse", hash_start, 0);
    chk("l_busy_wait", busy, 1);
    chk("l_time_hold", hash_time, 16'h0005);
    cyc();
    complete(16'hBEEF);
    chk("l_busy_done", busy, 0);
    cyc();
    chk("l_disp", disp_value, 16'hBEEF);
    chk("l_mode", disp_mode, 0);

    // Done on the last allowed WAIT cycle wins over the timeout.
    launch(16'h0008);
    cyc();
    repeat (7) cyc();
    chk("c_busy", busy, 1);
    complete(16'h2222);
    chk("c_busy_done", busy, 0);
    chk("c_no_err", timeout_err, 0);
    cyc();
    chk("c_disp", disp_value, 16'h2222);

    // Timeout after 8 WAIT cycles, then a normal relaunch.
    launch(16'h0009);
    cyc();
    repeat (7) cyc();
    chk("t_busy_7", busy, 1);
    chk("t_err_7", timeout_err, 0);
    cyc();
    chk("t_busy_8", busy, 0);
    chk("t_err", timeout_err, 1);
    cyc();
    chk("t_hash_kept", disp_value, 16'h2222);
    launch(16'h000A);
    chk("t_relaunch", hash_start, 1);
    chk("t_relaunch_time", hash_time, 16'h000A);
    cyc();
    complete(16'h1111);
    chk("t_busy_done", busy, 0);
    chk("t_err_sticky", timeout_err, 1);
    cyc();
    chk("t_disp", disp_value, 16'h1111);

    // Tick during WAIT is held and relaunched with cur_time seen in IDLE.
    launch(16'h0020);
    cyc(); cyc(); cyc();
    cur_time = 16'h0021;
    tick_in  = 1'b1;
    cyc();
    tick_in  = 1'b0;
    cur_time = 16'h0030;
    cyc();
    complete(16'h3333);
    chk("p_idle", busy, 0);
    chk("p_no_start", hash_start, 0);
    cur_time = 16'h0040;
    cyc();
    chk("p_start", hash_start, 1);
    chk("p_time", hash_time, 16'h0040);
    cyc();
    complete(16'h4444);
    cyc();
    chk("p_drained", busy, 0);
    chk("p_disp", disp_value, 16'h4444);

    // Display modes and frozen hash.
    cur_time = 16'h0055;
    press();
    chk("m1_mode", disp_mode, 1);
    chk("m1_disp", disp_value, 16'h0055);
    press();
    chk("m2_mode", disp_mode, 2);
    chk("m2_disp", disp_value, 16'h1234);
    press();
    chk("m3_mode", disp_mode, 3);
    chk("m3_disp", disp_value, 16'h4444);
    launch(16'h0060);
    cyc();
    complete(16'h5555);
    cyc();
    chk("m3_frozen", disp_value, 16'h4444);
    press();
    chk("m0_mode", disp_mode, 0);
    chk("m0_disp", disp_value, 16'h5555);
    press(); press();
    launch(16'h0061);
    cyc();
    button_pulse = 1'b1;
    complete(16'h6666);
    button_pulse = 1'b0;
    chk("mc_mode", disp_mode, 3);
    chk("mc_frozen_pre", disp_value, 16'h5555);
    press();
    chk("mc_live", disp_value, 16'h6666);

`ifdef HASH_SCHED_OVERRUN_CNT_EN
    launch(16'h0070);
    cyc();
    tick_in = 1'b1;
    cyc(); cyc(); cyc();
    tick_in = 1'b0;
    chk("o_missed_2", missed_ticks, 2);
    complete(16'h7070);
    cyc(); cyc();
    complete(16'h7171);
    chk("o_idle", busy, 0);
    tick_in = 1'b1;
    repeat (600) cyc();
    tick_in = 1'b0;
    chk("o_saturate", missed_ticks, 8'hFF);
    repeat (40) cyc();
    chk("o_drained", busy, 0);
    chk("o_hash_kept", disp_value, 16'h7171);
`endif

    // Asynchronous reset in WAIT with a coincident done.
    launch(16'h0080);
    cyc();
    hash_result = 16'h7777;
    hash_done   = 1'b1;
    #200;
    reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_start", hash_start, 0);
    chk("ar_time", hash_time, 0);
    chk("ar_id", hash_id, 0);
    chk("ar_disp", disp_value, 0);
    chk("ar_err", timeout_err, 0);
`ifdef HASH_SCHED_OVERRUN_CNT_EN
    chk("ar_missed", missed_ticks, 0);
`endif
    cyc();
    chk("ar_state_held", state_dbg, 0);
    reset     = 1'b0;
    hash_done = 1'b0;
    cyc();
    chk("ar_idle", busy, 0);
    chk("ar_no_capture", disp_value, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
